// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller for the laRVa data bus.
// Latches NSRC sources as edge- or level-triggered pending bits, masks them
// with ENABLE, picks the lowest active index and drives a registered irq /
// ivector pair. Bus reads have one cycle of registered latency.
// Word map: 0 PEND, 1 ENABLE, 2 SET/src, 3 VECBASE, 4 MODE, 6 CLAIM,
// 5 and 7 read 0 and ignore writes.
module irq_ctrl #(
    parameter int          NSRC      = 8,
    parameter logic [29:0] VBASE_RST = 30'h0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cs,
    input  logic [2:0]      addr,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    output logic [31:0]     rdata,
    input  logic [NSRC-1:0] src,
    output logic            irq,
    output logic [29:0]     ivector
);

    localparam logic [2:0] A_PEND  = 3'd0;
    localparam logic [2:0] A_EN    = 3'd1;
    localparam logic [2:0] A_SET   = 3'd2;
    localparam logic [2:0] A_VBASE = 3'd3;
    localparam logic [2:0] A_MODE  = 3'd4;
    localparam logic [2:0] A_CLAIM = 3'd6;

    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] pend_q,  pend_d;
    logic [NSRC-1:0] slat_q,  slat_d;
    logic [NSRC-1:0] en_q,    en_d;
    logic [NSRC-1:0] mode_q,  mode_d;
    logic [29:0]     vbase_q, vbase_d;
    logic            irq_q,   irq_d;
    logic [29:0]     ivec_q,  ivec_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            wr_en;
    logic [31:0]     bmask;
    logic [31:0]     wbits;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] setw;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] active;
    logic [3:0]      sel;
    logic            any_act;
    logic [31:0]     claim;

    // Bus write decode: byte-lane mask, W1C and SET vectors, edge detect.
    always_comb begin
        wr_en = cs & (|wstrb);
        bmask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
        wbits = wdata & bmask;
        w1c   = (wr_en && addr == A_PEND) ? wbits[NSRC-1:0] : '0;
        setw  = (wr_en && addr == A_SET)  ? wbits[NSRC-1:0] : '0;
        rise  = src & ~src_q;
    end

    // Pending update: sets are OR-ed in after the clear so a same-cycle set wins;
    // level bits follow the source, so they cannot be cleared while src is high.
    always_comb begin
        slat_d = (slat_q & ~w1c) | setw;
        pend_d = (mode_q & ((pend_q & ~w1c) | rise | setw))
               | (~mode_q & (src | slat_d));
    end

    // Control register writes, merged byte by byte.
    always_comb begin
        en_d    = en_q;
        mode_d  = mode_q;
        vbase_d = vbase_q;
        if (wr_en && addr == A_EN)
            en_d = (en_q & ~bmask[NSRC-1:0]) | wbits[NSRC-1:0];
        if (wr_en && addr == A_MODE)
            mode_d = (mode_q & ~bmask[NSRC-1:0]) | wbits[NSRC-1:0];
        if (wr_en && addr == A_VBASE)
            vbase_d = (vbase_q & ~bmask[31:2]) | wbits[31:2];
    end

    // Priority select: lowest active index wins; builds next irq/ivector and CLAIM.
    always_comb begin
        active  = pend_q & en_q;
        any_act = |active;
        sel     = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i])
                sel = i[3:0];
        end
        irq_d  = any_act;
        ivec_d = any_act ? (vbase_q + {24'd0, sel, 2'b00}) : vbase_q;
        claim  = any_act ? {1'b1, 27'd0, sel} : 32'd0;
    end

    // Read mux: samples pre-write state; zero when not selected.
    always_comb begin
        rdata_d = 32'd0;
        if (cs) begin
            case (addr)
                A_PEND:  rdata_d = 32'(pend_q);
                A_EN:    rdata_d = 32'(en_q);
                A_SET:   rdata_d = 32'(src);
                A_VBASE: rdata_d = {vbase_q, 2'b00};
                A_MODE:  rdata_d = 32'(mode_q);
                A_CLAIM: rdata_d = claim;
                default: rdata_d = 32'd0;
            endcase
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q   <= '0;
            pend_q  <= '0;
            slat_q  <= '0;
            en_q    <= '0;
            mode_q  <= '0;
            vbase_q <= VBASE_RST;
            irq_q   <= 1'b0;
            ivec_q  <= VBASE_RST;
            rdata_q <= 32'd0;
        end else begin
            src_q   <= src;
            pend_q  <= pend_d;
            slat_q  <= slat_d;
            en_q    <= en_d;
            mode_q  <= mode_d;
            vbase_q <= vbase_d;
            irq_q   <= irq_d;
            ivec_q  <= ivec_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata   = rdata_q;
    assign irq     = irq_q;
    assign ivector = ivec_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: directed scenarios followed by random bus traffic
// and source activity, checked cycle by cycle against a per-source model.
module tb_irq_ctrl;

    localparam int          NSRC   = 8;
    localparam logic [29:0] VB_RST = 30'h0000_0123;

    logic        clk;
    logic        reset;
    logic        cs;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic [7:0]  src;
    logic        irq;
    logic [29:0] ivector;

    logic [7:0]  src_v;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit          irq;
        int unsigned ivec;
        int unsigned rd;
    } exp_t;

    exp_t sbq[$];

    // Reference model state, one entry per source.
    bit          m_pend [8];
    bit          m_lat  [8];
    bit          m_prev [8];
    bit          m_mode [8];
    bit          m_en   [8];
    int unsigned m_vbase;

    irq_ctrl #(.NSRC(NSRC), .VBASE_RST(VB_RST)) dut (
        .clk(clk), .reset(reset), .cs(cs), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .src(src), .irq(irq), .ivector(ivector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin
            m_pend[i] = 0; m_lat[i] = 0; m_prev[i] = 0; m_mode[i] = 0; m_en[i] = 0;
        end
        m_vbase = 32'(VB_RST);
    endtask

    // Predicts the outputs after the coming edge, then advances the model.
    task automatic model_step(input bit c, input bit [2:0] a, input logic [31:0] wd,
                              input bit [3:0] ws, input bit [7:0] s, output exp_t e);
        int          first;
        int unsigned rv;
        int unsigned vb32;
        bit          wr, w1c, setb, nlat;
        first = -1;
        for (int i = 0; i < 8; i++)
            if (m_pend[i] && m_en[i] && first < 0) first = i;
        e.irq  = (first >= 0);
        e.ivec = (first >= 0) ? ((m_vbase + int'(unsigned'(first)) * 16 / 4) & 32'h3FFF_FFFF) : m_vbase;
        rv = 0;
        case (a)
            3'd0: for (int i = 0; i < 8; i++) if (m_pend[i]) rv += (1 << i);
            3'd1: for (int i = 0; i < 8; i++) if (m_en[i])   rv += (1 << i);
            3'd2: rv = 32'(s);
            3'd3: rv = m_vbase * 4;
            3'd4: for (int i = 0; i < 8; i++) if (m_mode[i]) rv += (1 << i);
            3'd6: rv = (first >= 0) ? (32'h8000_0000 + first) : 0;
            default: rv = 0;
        endcase
        e.rd = c ? rv : 0;
        wr = c && (ws != 0);
        for (int i = 0; i < 8; i++) begin
            w1c  = wr && a == 3'd0 && ws[i/8] && wd[i];
            setb = wr && a == 3'd2 && ws[i/8] && wd[i];
            nlat = setb || (m_lat[i] && !w1c);
            if (m_mode[i])
                m_pend[i] = setb || (s[i] && !m_prev[i]) || (m_pend[i] && !w1c);
            else
                m_pend[i] = s[i] || nlat;
            m_lat[i]  = nlat;
            m_prev[i] = s[i];
        end
        if (wr && a == 3'd1)
            for (int i = 0; i < 8; i++) if (ws[i/8]) m_en[i] = wd[i];
        if (wr && a == 3'd4)
            for (int i = 0; i < 8; i++) if (ws[i/8]) m_mode[i] = wd[i];
        if (wr && a == 3'd3) begin
            vb32 = m_vbase << 2;
            for (int b = 0; b < 4; b++)
                if (ws[b]) vb32[8*b +: 8] = wd[8*b +: 8];
            m_vbase = vb32 >> 2;
        end
    endtask

    // One bus cycle: drive at the falling edge, queue what the next edge must show.
    task automatic tick(input bit c, input bit [2:0] a, input logic [31:0] wd, input bit [3:0] ws);
        exp_t e;
        @(negedge clk);
        cs = c; addr = a; wdata = wd; wstrb = ws; src = src_v;
        model_step(c, a, wd, ws, src_v, e);
        sbq.push_back(e);
    endtask

    task automatic wr(input bit [2:0] a, input logic [31:0] d, input bit [3:0] s = 4'hF);
        tick(1'b1, a, d, s);
    endtask

    task automatic rd(input bit [2:0] a);
        tick(1'b1, a, 32'd0, 4'h0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 3'd0, 32'd0, 4'h0);
    endtask

    // Monitor: each edge that has a queued expectation is checked just after it.
    always @(posedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            #1;
            check("irq",     32'(irq),     32'(e.irq));
            check("ivector", 32'(ivector), e.ivec);
            check("rdata",   rdata,        e.rd);
        end
    end

    initial begin
        int r;
        reset = 1'b1; cs = 1'b0; addr = 3'd0; wdata = 32'd0; wstrb = 4'h0;
        src_v = 8'h00; src = 8'h00;
        m_reset();
        repeat (2) @(posedge clk);
        #2;
        check("reset_rdata",   rdata,         32'd0);
        check("reset_irq",     32'(irq),      32'd0);
        check("reset_ivector", 32'(ivector),  32'(VB_RST));
        @(negedge clk); #2;
        reset = 1'b0;

        // edge capture
        wr(3'd4, 32'hFF); wr(3'd1, 32'h04); wr(3'd3, 32'h1000);
        src_v = 8'h04; idle(1); src_v = 8'h00; idle(3);
        rd(3'd0); rd(3'd6); wr(3'd0, 32'h04); idle(2); rd(3'd6);

        // priority between sources 5 and 1
        wr(3'd1, 32'h22); src_v = 8'h22; idle(1); src_v = 8'h00; idle(3);
        rd(3'd6); wr(3'd0, 32'h02); idle(3); rd(3'd6); wr(3'd0, 32'h20); idle(2);

        // level mode on source 3
        wr(3'd4, 32'h00); wr(3'd1, 32'h08); src_v = 8'h08; idle(3);
        wr(3'd0, 32'h08); idle(3); rd(3'd0); src_v = 8'h00; idle(3); rd(3'd0);

        // masking, SET and byte strobes
        wr(3'd1, 32'h00); wr(3'd2, 32'h01); idle(2); rd(3'd0);
        wr(3'd1, 32'h01); idle(3);
        wr(3'd1, 32'h0000_AAFE, 4'b0010); rd(3'd1);
        wr(3'd3, 32'h5566_7788, 4'b0100); rd(3'd3);
        wr(3'd0, 32'h01); idle(3); rd(3'd0);

        // set beats clear in the same cycle, and unused offsets
        wr(3'd4, 32'h01); wr(3'd1, 32'h01); idle(2);
        src_v = 8'h01; wr(3'd0, 32'h01); idle(2); rd(3'd0); src_v = 8'h00;
        wr(3'd5, 32'hFFFF_FFFF); rd(3'd5); wr(3'd7, 32'hFFFF_FFFF); rd(3'd7);

        // VECBASE wrap-around
        wr(3'd3, 32'hFFFF_FFF0); wr(3'd1, 32'hFF); wr(3'd2, 32'h80); idle(3); rd(3'd3);
        wr(3'd0, 32'hFF); idle(2);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) < 3) src_v = src_v ^ (8'h01 << $urandom_range(0, 7));
            r = $urandom_range(0, 9);
            if (r < 4)      idle(1);
            else if (r < 7) rd(3'($urandom_range(0, 7)));
            else            wr(3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
        end

        // reset asserted in the middle of a read
        src_v = 8'h00;
        wr(3'd3, 32'h0000_4000); wr(3'd4, 32'h01); wr(3'd1, 32'h01); wr(3'd2, 32'h01);
        idle(2); rd(3'd1);
        @(posedge clk); #2;
        reset = 1'b1; cs = 1'b0;
        #1;
        check("async_rdata",   rdata,        32'd0);
        check("async_irq",     32'(irq),     32'd0);
        check("async_ivector", 32'(ivector), 32'(VB_RST));
        sbq.delete();
        m_reset();
        @(negedge clk); #2;
        reset = 1'b0;
        rd(3'd0); rd(3'd1); rd(3'd3); idle(2);
        @(posedge clk); #3;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
